// File: rtl/bbot_quad_pkg.sv
// Shared definitions for the BBot quadrature generator and counter:
// FSM state encoding, direction constants and the phase-to-A/B mapping.
package bbot_quad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } quad_state_t;

    localparam logic FWD = 1'b1;
    localparam logic REV = 1'b0;

    // Indexed by the 2-bit phase p: B = p[1], A = p[1] ^ p[0].
    // Forward walk of (A,B) is 00 -> 10 -> 11 -> 01 -> 00.
    localparam logic [3:0] PHASE_TO_A = 4'b0110;
    localparam logic [3:0] PHASE_TO_B = 4'b1100;

    // Next phase for one edge in the given direction (wraps mod 4).
    function automatic logic [1:0] phase_step(input logic [1:0] p, input logic dir);
        return (dir == FWD) ? (p + 2'd1) : (p - 2'd1);
    endfunction

endpackage

// File: rtl/bbot_quad_step_timer.sv
// Loadable down-counter that paces quadrature edges. tick is high while the
// count sits at 1; the owner reloads on that same cycle to keep a steady rate.
module bbot_quad_step_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clock,
    input  logic                reset_l,
    input  logic                load,
    input  logic [PERIOD_W-1:0] load_value,
    input  logic                enable,
    output logic                tick
);

    logic [PERIOD_W-1:0] count;

    // Load has priority; otherwise count down while enabled, parking at zero.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - PERIOD_W'(1);
        end
    end

    assign tick = (count == PERIOD_W'(1));

endmodule

// File: rtl/bbot_quadrature_generator.sv
// BBot quadrature generator: turns step commands into registered A/B
// quadrature edges with a running signed position.
// Optional index output Z is built when BBOT_QUADGEN_INDEX_EN is defined.
module bbot_quadrature_generator
    import bbot_quad_pkg::*;
#(
    parameter int COUNT_W  = 32,
    parameter int PERIOD_W = 16,
    parameter int CPR      = 2048
) (
    input  logic                clock,
    input  logic                reset_l,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [COUNT_W-1:0]  cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                abort,
    output logic                A,
    output logic                B,
    output logic                busy,
    output logic                done,
`ifdef BBOT_QUADGEN_INDEX_EN
    output logic                Z,
`endif
    output logic [COUNT_W-1:0]  position
);

    quad_state_t         state;
    quad_state_t         state_next;

    logic                dir;
    logic [COUNT_W-1:0]  remaining;
    logic [PERIOD_W-1:0] period;
    logic [1:0]          phase;
    logic [1:0]          phase_next;

    logic                accept;
    logic                step_en;
    logic                tick;
    logic                timer_load;
    logic [PERIOD_W-1:0] timer_value;
    logic [PERIOD_W-1:0] cmd_period_eff;

    // A zero period would never tick, so it runs at the fastest rate instead.
    assign cmd_period_eff = (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;

    assign accept  = cmd_valid && cmd_ready;
    // abort wins over a coincident tick: no edge on the cycle abort is seen.
    assign step_en = (state == ST_RUN) && tick && !abort;

    assign phase_next  = phase_step(phase, dir);
    assign timer_load  = accept || step_en;
    assign timer_value = accept ? cmd_period_eff : period;

    bbot_quad_step_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clock      (clock),
        .reset_l    (reset_l),
        .load       (timer_load),
        .load_value (timer_value),
        .enable     (state == ST_RUN),
        .tick       (tick)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (cmd_steps == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_FIN;
                end else if (tick && (remaining == COUNT_W'(1))) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_FIN: begin
                done = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // Latch the command on acceptance; count down remaining edges as they go out.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            dir       <= FWD;
            remaining <= '0;
            period    <= PERIOD_W'(1);
        end else if (accept) begin
            dir       <= cmd_dir;
            remaining <= cmd_steps;
            period    <= cmd_period_eff;
        end else if (step_en) begin
            remaining <= remaining - COUNT_W'(1);
        end
    end

    // Phase and registered A/B; phase carries over between commands.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            phase <= 2'd0;
            A     <= 1'b0;
            B     <= 1'b0;
        end else if (step_en) begin
            phase <= phase_next;
            A     <= PHASE_TO_A[phase_next];
            B     <= PHASE_TO_B[phase_next];
        end
    end

    // Running position, wrapping modulo 2^COUNT_W both ways.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            position <= '0;
        end else if (step_en) begin
            position <= (dir == FWD) ? (position + COUNT_W'(1))
                                     : (position - COUNT_W'(1));
        end
    end

`ifdef BBOT_QUADGEN_INDEX_EN
    localparam int               IDX_W   = (CPR > 1) ? $clog2(CPR) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(CPR - 1);

    logic [IDX_W-1:0] index;

    // Index counter follows position within one revolution, wrapping at CPR.
    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            index <= '0;
        end else if (step_en) begin
            if (dir == FWD) begin
                index <= (index == IDX_MAX) ? '0 : (index + IDX_W'(1));
            end else begin
                index <= (index == '0) ? IDX_MAX : (index - IDX_W'(1));
            end
        end
    end

    assign Z = (index == '0);
`endif

endmodule

// File: tb/tb_bbot_quadrature_generator.sv
// Self-checking bench for bbot_quadrature_generator (optional Z checks when
// BBOT_QUADGEN_INDEX_EN is defined).
module tb_bbot_quadrature_generator;

    localparam int COUNT_W  = 32;
    localparam int PERIOD_W = 16;
    localparam int TB_CPR   = 8;

    logic                clock = 1'b0;
    logic                reset_l = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic                cmd_dir = 1'b0;
    logic [COUNT_W-1:0]  cmd_steps = '0;
    logic [PERIOD_W-1:0] cmd_period = '0;
    logic                abort = 1'b0;
    logic                A;
    logic                B;
    logic                busy;
    logic                done;
    logic [COUNT_W-1:0]  position;
`ifdef BBOT_QUADGEN_INDEX_EN
    logic                Z;
`endif

    bbot_quadrature_generator #(
        .COUNT_W  (COUNT_W),
        .PERIOD_W (PERIOD_W),
        .CPR      (TB_CPR)
    ) dut (
        .clock      (clock),
        .reset_l    (reset_l),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
`ifdef BBOT_QUADGEN_INDEX_EN
        .Z          (Z),
`endif
        .position   (position)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference state: expected position, phase index and an external decoder.
    logic [COUNT_W-1:0] exp_pos = '0;
    int                 mphase  = 0;
    logic [COUNT_W-1:0] dec     = '0;
    logic [1:0]         ab_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    typedef struct {
        logic        dir;
        int          steps;
        int          period;
        int          abort_after;
        logic [31:0] exp_pos;
        logic [1:0]  exp_ab;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input logic d, input int steps, input int per,
                           input int abort_after, input string name);
        int         peff;
        int         exp_e;
        int         exp_done_t;
        int         limit;
        int         guard;
        int         edges;
        int         done_t;
        int         done_cnt;
        logic       ready_after;
        logic       aborted;
        logic       bad_time, bad_simul, bad_seq, bad_pos, bad_busy, bad_z;
        logic [1:0] prev, cur;

        peff       = (per == 0) ? 1 : per;
        exp_e      = (abort_after > 0 && abort_after < steps) ? abort_after : steps;
        exp_done_t = (exp_e < steps) ? exp_e * peff + 1 : steps * peff;
        limit      = steps * peff + 12;
        edges = 0; done_t = -1; done_cnt = 0; ready_after = 1'b0; aborted = 1'b0;
        bad_time = 0; bad_simul = 0; bad_seq = 0; bad_pos = 0; bad_busy = 0; bad_z = 0;

        guard = 0;
        @(negedge clock);
        while (!cmd_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (!cmd_ready) begin
            check({name, "_ready_wait"}, 64'(cmd_ready), 64'(1));
            return;
        end
        prev       = {A, B};
        cmd_valid  = 1'b1;
        cmd_dir    = d;
        cmd_steps  = COUNT_W'(steps);
        cmd_period = PERIOD_W'(per);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;

        for (int t = 0; t < limit; t++) begin
            @(negedge clock);
            abort = 1'b0;
            cur = {A, B};
            if (cur != prev) begin
                edges++;
                if (cur[1] != prev[1] && cur[0] != prev[0]) bad_simul = 1;
                if (t != edges * peff) bad_time = 1;
                mphase  = d ? mphase + 1 : mphase - 1;
                exp_pos = d ? exp_pos + 1 : exp_pos - 1;
                if (cur != ab_seq[mphase & 3]) bad_seq = 1;
                dec = (cur[1] ^ prev[0]) ? dec + 1 : dec - 1;
            end
            prev = cur;
            if (position !== exp_pos) bad_pos = 1;
`ifdef BBOT_QUADGEN_INDEX_EN
            if (Z !== ((exp_pos % TB_CPR) == 0)) bad_z = 1;
`endif
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) done_t = t;
            end
            if (done_t < 0 || t == done_t) begin
                if (busy !== 1'b1) bad_busy = 1;
            end
            if (done_t >= 0 && t == done_t + 1) begin
                ready_after = cmd_ready;
                if (busy !== 1'b0) bad_busy = 1;
                cmd_valid = 1'b0;
                break;
            end
            // Garbage command while busy must be ignored.
            cmd_valid  = 1'b1;
            cmd_dir    = 1'($urandom);
            cmd_steps  = COUNT_W'($urandom_range(0, 7));
            cmd_period = PERIOD_W'($urandom_range(0, 3));
            if (exp_e < steps && edges == abort_after && !aborted) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;

        check({name, "_done_time"}, 64'(done_t), 64'(exp_done_t));
        check({name, "_done_count"}, 64'(done_cnt), 64'(1));
        check({name, "_ready_after"}, 64'(ready_after), 64'(1));
        check({name, "_edges"}, 64'(edges), 64'(exp_e));
        check({name, "_edge_timing"}, 64'(bad_time), 64'(0));
        check({name, "_no_simul"}, 64'(bad_simul), 64'(0));
        check({name, "_ab_seq"}, 64'(bad_seq), 64'(0));
        check({name, "_pos_track"}, 64'(bad_pos), 64'(0));
        check({name, "_busy"}, 64'(bad_busy), 64'(0));
        check({name, "_decoder"}, 64'(dec), 64'(position));
`ifdef BBOT_QUADGEN_INDEX_EN
        check({name, "_index"}, 64'(bad_z), 64'(0));
`endif
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1'b1,   8, 4, 0, 32'd8,   2'b00};
        vecs[1] = '{1'b1, 100, 1, 0, 32'd108, 2'b00};
        vecs[2] = '{1'b0,  40, 1, 0, 32'd68,  2'b00};
        vecs[3] = '{1'b1,   3, 0, 0, 32'd71,  2'b01};
        vecs[4] = '{1'b1,   0, 5, 0, 32'd71,  2'b01};
        vecs[5] = '{1'b1,  20, 2, 5, 32'd76,  2'b00};
        vecs[6] = '{1'b0,   0, 1, 0, 32'd76,  2'b00};

        // Reset state
        #12;
        check("rst_A", 64'(A), 64'(0));
        check("rst_B", 64'(B), 64'(0));
        check("rst_position", 64'(position), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_ready", 64'(cmd_ready), 64'(1));
`ifdef BBOT_QUADGEN_INDEX_EN
        check("rst_Z", 64'(Z), 64'(1));
`endif
        @(negedge clock);
        reset_l = 1'b1;

        // abort while idle is ignored
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("idle_abort_busy", 64'(busy), 64'(0));
        check("idle_abort_done", 64'(done), 64'(0));
        check("idle_abort_ready", 64'(cmd_ready), 64'(1));

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_cmd(vecs[i].dir, vecs[i].steps, vecs[i].period, vecs[i].abort_after,
                    $sformatf("vec%0d", i));
            check($sformatf("vec%0d_position", i), 64'(position), 64'(vecs[i].exp_pos));
            check($sformatf("vec%0d_ab", i), 64'({A, B}), 64'(vecs[i].exp_ab));
        end

        // Reset in the middle of a running command
        @(negedge clock);
        cmd_valid  = 1'b1;
        cmd_dir    = 1'b1;
        cmd_steps  = 32'd20;
        cmd_period = 16'd3;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (7) @(negedge clock);
        reset_l = 1'b0;
        #1;
        check("midrst_A", 64'(A), 64'(0));
        check("midrst_B", 64'(B), 64'(0));
        check("midrst_position", 64'(position), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_ready", 64'(cmd_ready), 64'(1));
        exp_pos = '0;
        mphase  = 0;
        dec     = '0;
        @(negedge clock);
        reset_l = 1'b1;

        // Reverse one step from reset wraps to all ones
        run_cmd(1'b0, 1, 1, 0, "rev1");
        check("rev1_position", 64'(position), 64'(32'hFFFF_FFFF));
        check("rev1_ab", 64'({A, B}), 64'(2'b01));

        // Forward a full two revolutions of the index range
        run_cmd(1'b1, 17, 1, 0, "fwd17");
        check("fwd17_position", 64'(position), 64'(32'd16));

        // Randomized commands against the reference model
        for (int r = 0; r < 16; r++) begin
            logic d;
            int   s, p, ab;
            d  = 1'($urandom_range(0, 1));
            s  = $urandom_range(0, 12);
            p  = $urandom_range(0, 4);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            run_cmd(d, s, p, ab, $sformatf("rnd%0d", r));
            check($sformatf("rnd%0d_position", r), 64'(position), 64'(exp_pos));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bbot_quadrature_generator.md
# bbot_quadrature_generator

Synthesizes two-phase quadrature signals (A/B) from step commands. It serves as the transmit-side counterpart to the BBot quadrature counter: a stimulus source for encoder-less bring-up, loopback self-test, and simulated wheel motion. It sits in the BBot FPGA beside the motor/encoder blocks and can be wired directly to a quadrature counter's A/B inputs.

## Interface
Parameters:
- COUNT_W, 32, width of step count and position
- PERIOD_W, 16, width of edge-period field
- CPR, 2048, counts per revolution for index generation (used only with index feature)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_l  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high when idle and able to accept a command
- cmd_dir  in  1  1 = forward (counter counts up), 0 = reverse
- cmd_steps  in  COUNT_W  number of A/B edges to emit, unsigned
- cmd_period  in  PERIOD_W  clocks between successive edges; 0 treated as 1
- abort  in  1  stop the current command after the current cycle
- A  out  1  quadrature phase A, registered
- B  out  1  quadrature phase B, registered
- busy  out  1  command in progress
- done  out  1  one-cycle pulse on command completion or abort
- position  out  COUNT_W  signed running edge count, matching what a decoder counts
- Z  out  1  index pulse (present only with BBOT_QUADGEN_INDEX_EN)

## Operation
- 2-bit phase p. Output mapping: B = p[1], A = p[1]^p[0]. Forward sequence (A,B): 00→10→11→01→00; p increments mod 4. Reverse decrements p.
- A decoder that counts up when A ^ B_previous on any change counts +1 per forward edge and −1 per reverse edge.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch dir, steps, and period (0→1); load timer=period. If steps==0, go to FIN; else go to RUN.
  - RUN: timer decrements each cycle. When timer==1: step p, position ±1, remaining−1, reload timer. After the final edge (remaining reaches 0), go to FIN.
  - FIN: done=1 for one cycle, then go to IDLE.
- abort in RUN: go to FIN on the next edge with no further phase change. abort in IDLE or FIN is ignored.
- position wraps modulo 2^COUNT_W in both directions. Phase continues from its last value across commands and is never re-homed.
- cmd_* inputs are ignored when cmd_ready=0.

## Timing
- Reset values: A=0, B=0, p=0, position=0, busy=0, done=0, cmd_ready=1, FSM=IDLE, Z=1 (index enabled).
- Command accepted at clock edge k. Edge n (1..N) appears on A/B and position at edge k+n·period.
- done is high during the cycle after edge k+N·period. cmd_ready rises with the cycle after done, so a new command can be accepted at k+N·period+2.
- steps==0: done is high in the cycle following acceptance; A/B do not change.
- busy = (FSM != IDLE).
- Minimum edge spacing is 1 clock (period=1). A/B never change simultaneously.
- abort sampled high at edge j in RUN: no phase change at edge j. done is high during the cycle after j.
- Reset asserted mid-command: all state returns to its reset values asynchronously. An external decoder sees A/B forced to 00.

## Configuration
- BBOT_QUADGEN_INDEX_EN defined: adds port Z and an index counter in 0..CPR−1 that moves with position and wraps in both directions. Z=1 while the index counter==0, otherwise 0.
- Undefined: no Z port and no index logic.

## Structure
- Shared package bbot_quad_pkg: FSM state encoding (IDLE/RUN/FIN), phase-to-A/B mapping constants, and direction constants FWD/REV. The quadrature counter uses the same package.
- One sub-module, bbot_quad_step_timer: loadable PERIOD_W down-counter with a tick output at 1. Everything else lives in the top module.

## Test plan
- Reset, then cmd dir=1, steps=8, period=4: A/B follow 10,11,01,00 twice, with edges every 4 clocks. Final position=8, done pulses once, final A/B=00.
- Loopback into a quadrature counter: steps=100 forward, then 40 reverse, at period=1 → counter CurrentCount=60 and position=60.
- cmd_period=0 and steps=3: edges every clock (same as period=1). steps=0: done next cycle, no A/B change.
- abort asserted after 5 edges of a 20-step, period=2 command: position=5, no further edges, single done pulse, cmd_ready returns.
- Reverse from reset for 1 step: A/B=01, position=all ones (−1 wrap). Reset asserted mid-run → A/B=00, position=0 immediately.
- With BBOT_QUADGEN_INDEX_EN and CPR=8: forward 16 steps → Z high at position 0, 8, and 16 only. Reverse 1 step from 0 → Z low, index counter=7.
